// File: rtl/true_form_accum_ctrl_pkg.sv
// Shared types and sign-magnitude helpers
// for the true-form burst accumulator.
package true_form_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_e;

  localparam int SM_MAX_W = 64;
  localparam logic [SM_MAX_W-1:0] SM_ZERO = '0;

  function automatic logic sm_sign(
    input logic [SM_MAX_W-1:0] v,
    input int unsigned         w
  );
    return v[w-1];
  endfunction

  function automatic logic [SM_MAX_W-1:0] sm_mag(
    input logic [SM_MAX_W-1:0] v,
    input int unsigned         w
  );
    logic [SM_MAX_W-1:0] mask;
    mask = (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
    return v & mask;
  endfunction

endpackage

// File: rtl/true_form_accum_ctrl_sm_add_core.sv
// Combinational sign-magnitude adder with
// magnitude-overflow flag and canonical +0.
module sm_add_core
  import true_form_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             of
);

  localparam int MW = WIDTH - 1;

  logic          sa;
  logic          sb;
  logic [MW-1:0] ma;
  logic [MW-1:0] mb;
  logic [MW-1:0] mag;
  logic [MW:0]   sum;
  logic          sgn;

  assign sa = sm_sign(SM_MAX_W'(a), WIDTH);
  assign sb = sm_sign(SM_MAX_W'(b), WIDTH);
  assign ma = MW'(sm_mag(SM_MAX_W'(a), WIDTH));
  assign mb = MW'(sm_mag(SM_MAX_W'(b), WIDTH));
  assign sum = {1'b0, ma} + {1'b0, mb};

  always_comb begin
    mag = '0;
    sgn = 1'b0;
    of  = 1'b0;
    if (sa == sb) begin
      mag = sum[MW-1:0];
      sgn = sa;
      of  = sum[MW];
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    // zero magnitude is always emitted as +0
    s = (mag == '0) ? WIDTH'(SM_ZERO) : {sgn, mag};
  end

endmodule

// File: rtl/true_form_accum_ctrl.sv
// Burst accumulator controller: folds a stream
// of true-form operands into one result.
module true_form_accum_ctrl
  import true_form_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_of
);

  acc_state_e       state_q;
  acc_state_e       state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] rem_d;
  logic             of_q;
  logic             of_d;
  logic [WIDTH-1:0] add_s;
  logic             add_of;

  sm_add_core #(
    .WIDTH(WIDTH)
  ) u_add (
    .a (acc_q),
    .b (in_data),
    .s (add_s),
    .of(add_of)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= WIDTH'(SM_ZERO);
      rem_q   <= '0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      of_q    <= of_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    of_d    = of_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d = WIDTH'(SM_ZERO);
          of_d  = 1'b0;
          if (len_i == '0) begin
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d = (len_i > LEN_W'(MAX_LEN)) ?
                    LEN_W'(MAX_LEN) : len_i;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_s;
          of_d  = of_q | add_of;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q != IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_of    = of_q;

endmodule
